// File: rtl/pipe_pkg.sv
// Shared widths, reset constants and control-bundle field positions
// for the fetch/decode pipeline slice.
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 16;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Bit positions inside the ID-stage control bundle
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC   = 4;
    localparam int CTRL_ALU_OP_LO = 5;
    localparam int CTRL_ALU_OP_HI = 6;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_JUMP      = 8;
    localparam int CTRL_REG_DST   = 9;

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Hazard controls in, fetch/decode pipeline state out.
// slave: the pipeline; master: hazard unit / fetch memory / decoder side.
interface fetch_decode_pipe_if
    import pipe_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int CTRL_W_P = CTRL_W,
    parameter int CNT_W_P  = CNT_W
);
    logic                PCWrite;
    logic                IF_IDWrite;
    logic                memRegWriteSelection;
    logic                branch_taken;
    logic [XLEN_P-1:0]   branch_target;
    logic [XLEN_P-1:0]   imem_instr;
    logic [CTRL_W_P-1:0] id_ctrl;

    logic [XLEN_P-1:0]   pc;
    logic [XLEN_P-1:0]   if_id_instr;
    logic [XLEN_P-1:0]   if_id_pc4;
    logic                if_id_valid;
    logic [CTRL_W_P-1:0] id_ex_ctrl;
    logic                id_ex_valid;
    logic [CNT_W_P-1:0]  stall_count;
    logic [CNT_W_P-1:0]  flush_count;

    modport slave (
        input  PCWrite, IF_IDWrite, memRegWriteSelection,
        input  branch_taken, branch_target, imem_instr, id_ctrl,
        output pc, if_id_instr, if_id_pc4, if_id_valid,
        output id_ex_ctrl, id_ex_valid, stall_count, flush_count
    );

    modport master (
        output PCWrite, IF_IDWrite, memRegWriteSelection,
        output branch_taken, branch_target, imem_instr, id_ctrl,
        input  pc, if_id_instr, if_id_pc4, if_id_valid,
        input  id_ex_ctrl, id_ex_valid, stall_count, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear.
// Ports: clk, rst_n, inc (count enable), count (stops at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// PC, IF/ID and ID/EX control registers with hold, bubble and flush.
// Ports: clk, rst_n, bus (slave side of fetch_decode_pipe_if).
module fetch_decode_pipe
    import pipe_pkg::*;
#(
    parameter int          XLEN_P    = XLEN,
    parameter int          CTRL_W_P  = CTRL_W,
    parameter logic [31:0] RESET_PC_P  = RESET_PC,
    parameter logic [31:0] NOP_INSTR_P = NOP_INSTR,
    parameter int          CNT_W_P   = CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    fetch_decode_pipe_if.slave bus
);

    logic [XLEN_P-1:0]   pc_plus4;
    logic [CTRL_W_P-1:0] ctrl_next;
    logic                stall_inc;

    assign pc_plus4 = bus.pc + XLEN_P'(4);

    // An empty IF/ID slot never forwards live control into EX.
    assign ctrl_next = bus.if_id_valid ? bus.id_ctrl : '0;

    // A flush cycle counts as a flush only, never as a stall.
    assign stall_inc = !bus.PCWrite && !bus.branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc <= XLEN_P'(RESET_PC_P);
        end else if (bus.branch_taken) begin
            bus.pc <= bus.branch_target;
        end else if (bus.PCWrite) begin
            bus.pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_id_instr <= XLEN_P'(NOP_INSTR_P);
            bus.if_id_pc4   <= '0;
            bus.if_id_valid <= 1'b0;
        end else if (bus.branch_taken) begin
            bus.if_id_instr <= XLEN_P'(NOP_INSTR_P);
            bus.if_id_pc4   <= '0;
            bus.if_id_valid <= 1'b0;
        end else if (bus.IF_IDWrite) begin
            bus.if_id_instr <= bus.imem_instr;
            bus.if_id_pc4   <= pc_plus4;
            bus.if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.id_ex_ctrl  <= '0;
            bus.id_ex_valid <= 1'b0;
        end else if (bus.branch_taken || bus.memRegWriteSelection) begin
            bus.id_ex_ctrl  <= '0;
            bus.id_ex_valid <= 1'b0;
        end else begin
            bus.id_ex_ctrl  <= ctrl_next;
            bus.id_ex_valid <= bus.if_id_valid;
        end
    end

    sat_counter #(.CNT_W(CNT_W_P)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    sat_counter #(.CNT_W(CNT_W_P)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.branch_taken),
        .count (bus.flush_count)
    );

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed plus randomized bench for fetch_decode_pipe (CNT_W=4 build).
// Reference model tracks the architectural pipeline state per cycle.
module tb_fetch_decode_pipe;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_decode_pipe_if #(.XLEN_P(32), .CTRL_W_P(10), .CNT_W_P(CW)) bus ();

    fetch_decode_pipe #(.CNT_W_P(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_pc, m_ii, m_ipc4;
    logic        m_iv, m_ev;
    logic [9:0]  m_ctrl;
    int          m_sc, m_fc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ii = 32'h0; m_ipc4 = 32'h0; m_iv = 1'b0;
        m_ctrl = 10'h0; m_ev = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    // Next state from the current inputs; all right-hand sides use
    // values from before the edge.
    task automatic model_edge();
        logic [31:0] pc0;
        logic        iv0;
        pc0 = m_pc;
        iv0 = m_iv;
        if (bus.branch_taken) begin
            m_pc = bus.branch_target;
            m_ii = 32'h0; m_ipc4 = 32'h0; m_iv = 1'b0;
            m_ctrl = 10'h0; m_ev = 1'b0;
            if (m_fc < CMAX) m_fc++;
        end else begin
            if (bus.PCWrite) m_pc = pc0 + 32'd4;
            else if (m_sc < CMAX) m_sc++;
            if (bus.IF_IDWrite) begin
                m_ii = bus.imem_instr; m_ipc4 = pc0 + 32'd4; m_iv = 1'b1;
            end
            if (bus.memRegWriteSelection) begin
                m_ctrl = 10'h0; m_ev = 1'b0;
            end else begin
                m_ctrl = iv0 ? bus.id_ctrl : 10'h0;
                m_ev = iv0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    bus.pc, m_pc);
        check({tag, ".ii"},    bus.if_id_instr, m_ii);
        check({tag, ".ipc4"},  bus.if_id_pc4, m_ipc4);
        check({tag, ".iv"},    32'(bus.if_id_valid), 32'(m_iv));
        check({tag, ".ctrl"},  32'(bus.id_ex_ctrl), 32'(m_ctrl));
        check({tag, ".ev"},    32'(bus.id_ex_valid), 32'(m_ev));
        check({tag, ".sc"},    32'(bus.stall_count), 32'(m_sc));
        check({tag, ".fc"},    32'(bus.flush_count), 32'(m_fc));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic mrs,
                         input logic bt, input logic [31:0] tgt);
        bus.PCWrite = pcw;
        bus.IF_IDWrite = ifw;
        bus.memRegWriteSelection = mrs;
        bus.branch_taken = bt;
        bus.branch_target = tgt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.imem_instr = 32'h8C01_0004;
        bus.id_ctrl = 10'h2A3;
        model_reset();
        #1;
        check_model("reset");
        #2 rst_n = 1'b1;

        // Normal fetch after reset
        step("t1c1");
        check("t1.pc", bus.pc, 32'h4);
        check("t1.ii", bus.if_id_instr, 32'h8C01_0004);
        bus.imem_instr = 32'h0000_1111;
        step("t1c2");
        check("t1.ctrl", 32'(bus.id_ex_ctrl), 32'h2A3);
        check("t1.ev", 32'(bus.id_ex_valid), 32'h1);

        // Load-use stall at pc=8
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.imem_instr = 32'h0000_2222;
        step("t2s");
        check("t2.pc", bus.pc, 32'h8);
        check("t2.sc", 32'(bus.stall_count), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step("t2r");
        check("t2.pc12", bus.pc, 32'hC);
        step("t2n");

        // Flush at pc=16
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step("t3");
        check("t3.pc", bus.pc, 32'h40);
        check("t3.fc", 32'(bus.flush_count), 32'h1);

        // Flush wins over stall
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        step("t4");
        check("t4.pc", bus.pc, 32'h100);
        check("t4.sc", 32'(bus.stall_count), 32'h1);

        // PC wrap
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("t5a");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step("t5b");
        check("t5.wrap", bus.pc, 32'h0);

        // Stall counter saturation
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < (1 << CW) + 5; i++) step("t5sat");
        check("t5.sat", 32'(bus.stall_count), 32'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                              : ($urandom & 32'hFFFF_FFFC));
            bus.imem_instr = $urandom;
            bus.id_ctrl = 10'($urandom_range(0, 1023));
            step("rand");
        end

        // Async reset in the middle of a stall, between edges
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step("t6s");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_model("t6rst");
        check("t6.pc", bus.pc, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.imem_instr = 32'h8C01_0004;
        #2 rst_n = 1'b1;
        step("t6c1");
        check("t6.pc4", bus.pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
